roc_ctrl: RTL and testbench
===========================

# roc_ctrl

Sequencing controller for the ring-oscillator counter (RO counter) entropy source. It runs in the system clock domain. For each random bit it opens a measurement window: it releases the RO counter from reset, enables it, and times how many system clocks pass until the counter's sticky `full` flag arrives. The LSB of that time is the raw random bit. Bits are packed into words and handed to the TRNG post-processing stage over a valid/ready handshake.

## Interface
Parameters:
- `WORD_W`, 32: bits per output word; ≥2.
- `TMR_W`, 16: width of the window timer.
- `TIMEOUT`, 16'hFFF0: timer value at which a window is declared dead; must be < 2^TMR_W − 1.
- `RST_CYC`, 4: clk cycles the RO counter is held in reset per window; ≥3.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run request from the control register.
- `ro_full`  in  1: `full` flag from the RO counter; asynchronous to `clk`.
- `cnt_rst`  out  1: reset to the RO counter.
- `cnt_en`  out  1: count enable to the RO counter.
- `data_out`  out  WORD_W: packed random word.
- `data_valid`  out  1: `data_out` valid.
- `data_ready`  in  1: consumer accepts the word.
- `busy`  out  1: high in every state except IDLE and ERR.
- `error`  out  1: sticky window-timeout flag.

## Operation
- `ro_full` passes through a 2-FF synchronizer to form `full_s`. No other logic samples `ro_full`.
- State `IDLE`: `cnt_rst`=1, `cnt_en`=0, bit count=0. When `enable`=1, go to `CLEAR`.
- State `CLEAR`: `cnt_rst`=1, `cnt_en`=0, timer=0. Stay for at least `RST_CYC` cycles **and** until `full_s`=0, then go to `COUNT`.
- State `COUNT`: `cnt_rst`=0, `cnt_en`=1, timer increments by 1 each cycle (mod 2^TMR_W).
  - If `full_s`=1: latch bit=timer[0] (value in that cycle, before increment) and go to `SAMPLE`.
  - Else, if timer==`TIMEOUT`: go to `ERR`.
  - `full_s` takes priority over timeout in the same cycle.
- State `SAMPLE`: `cnt_en`=0, `cnt_rst`=1. Update the shift register as shreg <= {shreg[WORD_W-2:0], bit} and increment bit count.
  - If the new count == `WORD_W`: load `data_out` <= new shreg, clear bit count, go to `OUT`.
  - Otherwise go to `CLEAR`.
  - The first collected bit lands in `data_out[WORD_W-1]`.
- State `OUT`: `data_valid`=1, `cnt_rst`=1. `data_out` is held stable until `data_valid && data_ready`.
  - On handshake: go to `CLEAR` if `enable`=1, else `IDLE`.
  - While in `OUT`, no new window starts.
- State `ERR`: `error`=1, `cnt_rst`=1, `cnt_en`=0. Leave to `IDLE` only when `enable`=0; `error` clears on that exit.
- `enable` dropping in `CLEAR`, `COUNT` or `SAMPLE`: next state is `IDLE`. Partial bits and bit count are discarded. A pending `SAMPLE` bit is dropped.
- `enable` dropping in `OUT`: the word is still delivered; the controller goes to `IDLE` after the handshake.

## Timing
- Reset values: `cnt_rst`=1, `cnt_en`=0, `data_out`=0, `data_valid`=0, `busy`=0, `error`=0, state=`IDLE`, synchronizer=0.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Synchronizer latency: `ro_full` rising before clk edge n is seen as `full_s`=1 in cycle n+2.
- Per-bit cost: `RST_CYC` (`CLEAR`) + k+1 (`COUNT`, where `full_s` seen at timer=k) + 1 (`SAMPLE`).
- `data_valid` rises in the cycle after the final `SAMPLE`.
- `data_valid` falls the cycle after the handshake.
- `data_ready` asserted before `data_valid` is legal; the handshake completes in the first `OUT` cycle.
- `rst` asserted mid-window: immediate return to reset values, and the RO counter is re-held in reset.

## Structure
- Shared package/header `roc_pkg.vh`: state encodings (`IDLE`, `CLEAR`, `COUNT`, `SAMPLE`, `OUT`, `ERR`, 3-bit) and the default parameter values.
- Sub-module `roc_sync2`: 2-FF synchronizer with async reset to 0. It is reused for any RO-domain flag.
- `roc_ctrl` contains the FSM, timer, bit counter, shift register and output register. The RO counter itself is instantiated one level up, beside `roc_ctrl`.

## Test plan
- Reset/idle: `rst` pulse, `enable`=0 for 20 cycles -> `cnt_rst`=1, `cnt_en`=0, `busy`=0, `data_valid`=0 throughout.
- Word assembly (`WORD_W`=4): bench asserts `ro_full` at `COUNT` timer values 3,4,3,4 (seen at 5,6,5,6) -> `data_out`=4'b1010, `data_valid` one cycle after the 4th `SAMPLE`.
- Backpressure: hold `data_ready`=0 for 10 cycles in `OUT` -> `data_out` stable, `cnt_en`=0, no new window. `data_ready`=1 -> `data_valid` drops next cycle and `CLEAR` begins.
- Timeout (`TIMEOUT`=16'h0010): never assert `ro_full` -> `ERR` after 17 `COUNT` cycles, `error`=1 and stays 1. Drop `enable` -> `error`=0, `IDLE`.
- Stale flag: keep `ro_full`=1 across `SAMPLE`, release 6 cycles into `CLEAR` -> `COUNT` starts only after `full_s`=0; no duplicate bit.
- Abort: drop `enable` in `COUNT` after 2 of 4 bits, re-enable -> next word built from 4 fresh bits; old bits absent.

Source files
------------

// File: rtl/roc_pkg.sv
// Shared state encoding and default parameters for the
// ring-oscillator counter sequencing controller.
package roc_pkg;

    localparam int              WORD_W_DEF  = 32;
    localparam int              TMR_W_DEF   = 16;
    localparam logic [15:0]     TIMEOUT_DEF = 16'hFFF0;
    localparam int              RST_CYC_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        COUNT  = 3'd2,
        SAMPLE = 3'd3,
        OUT    = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/roc_sync2.sv
// Two-flop synchronizer for flags arriving from the RO clock domain.
// Both flops clear to 0 on reset.
module roc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/roc_ctrl.sv
// Window sequencer for the RO counter entropy source: times each
// window to its full flag and packs the timer LSBs into words.
module roc_ctrl
    import roc_pkg::*;
#(
    parameter int               WORD_W  = WORD_W_DEF,
    parameter int               TMR_W   = TMR_W_DEF,
    parameter logic [TMR_W-1:0] TIMEOUT = TIMEOUT_DEF,
    parameter int               RST_CYC = RST_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ro_full,
    output logic              cnt_rst,
    output logic              cnt_en,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              error
);

    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int BC_W = $clog2(WORD_W + 1);

    state_t            r_state;
    state_t            w_next;
    logic [TMR_W-1:0]  r_timer;
    logic [RC_W-1:0]   r_rcnt;
    logic [BC_W-1:0]   r_bcnt;
    logic              r_bit;
    logic [WORD_W-2:0] r_shreg;
    logic [WORD_W-1:0] r_data;

    logic              w_full_s;
    logic [WORD_W-1:0] w_shreg_nxt;
    logic [BC_W-1:0]   w_bcnt_nxt;
    logic              w_word_done;
    logic              w_clr_done;
    logic              w_take;

    roc_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ro_full),
        .o_q (w_full_s)
    );

    assign w_shreg_nxt = {r_shreg, r_bit};
    assign w_bcnt_nxt  = r_bcnt + 1'b1;
    assign w_word_done = (w_bcnt_nxt == BC_W'(WORD_W));
    assign w_take      = (r_state == SAMPLE) && enable;

    // A stale full flag from the last window must clear before counting.
    assign w_clr_done = (r_rcnt >= RC_W'(RST_CYC - 1)) && !w_full_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_next = CLEAR;
            end
            CLEAR: begin
                if (!enable)         w_next = IDLE;
                else if (w_clr_done) w_next = COUNT;
            end
            COUNT: begin
                if (!enable)                w_next = IDLE;
                else if (w_full_s)          w_next = SAMPLE;
                else if (r_timer == TIMEOUT) w_next = ERR;
            end
            SAMPLE: begin
                if (!enable)          w_next = IDLE;
                else if (w_word_done) w_next = OUT;
                else                  w_next = CLEAR;
            end
            OUT: begin
                if (data_ready) w_next = enable ? CLEAR : IDLE;
            end
            ERR: begin
                if (!enable) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_rcnt  <= '0;
            r_bcnt  <= '0;
            r_bit   <= 1'b0;
            r_shreg <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_timer <= '0;
                if (r_rcnt < RC_W'(RST_CYC - 1)) r_rcnt <= r_rcnt + 1'b1;
            end else begin
                r_rcnt <= '0;
            end
            if (r_state == COUNT) begin
                r_timer <= r_timer + 1'b1;
                if (w_full_s) r_bit <= r_timer[0];
            end
            if (r_state == IDLE) r_bcnt <= '0;
            if (w_take) begin
                r_shreg <= w_shreg_nxt[WORD_W-2:0];
                r_bcnt  <= w_word_done ? '0 : w_bcnt_nxt;
                if (w_word_done) r_data <= w_shreg_nxt;
            end
        end
    end

    assign cnt_rst    = (r_state != COUNT);
    assign cnt_en     = (r_state == COUNT);
    assign data_out   = r_data;
    assign data_valid = (r_state == OUT);
    assign busy       = (r_state != IDLE) && (r_state != ERR);
    assign error      = (r_state == ERR);

endmodule

// File: tb/tb_roc_ctrl.sv
// Randomized scoreboard bench for roc_ctrl with a 4-bit word
// and a short timeout so the error path is reachable.
module tb_roc_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         ro_full = 1'b0;
    logic         data_ready = 1'b0;
    logic         cnt_rst;
    logic         cnt_en;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         error;

    int           vec = 0;
    int           errs = 0;
    logic [W-1:0] sb[$];
    int           bits[$];
    int           stall_req = -1;

    roc_ctrl #(
        .WORD_W  (W),
        .TMR_W   (16),
        .TIMEOUT (16'h0010),
        .RST_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ro_full    (ro_full),
        .cnt_rst    (cnt_rst),
        .cnt_en     (cnt_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        vec++;
        errs++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: pops expected words, applies random backpressure.
    logic         seen = 1'b0;
    logic         hs = 1'b0;
    logic         hs_en = 1'b0;
    logic [W-1:0] cur = '0;
    int           stall = 0;

    always @(negedge clk) begin
        if (hs) begin
            chk("valid_drop", data_valid, 0);
            chk("post_hs_busy", busy, hs_en);
        end
        hs = 1'b0;
        if (data_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    fail_now("unexpected_word");
                    cur = data_out;
                end else begin
                    cur = sb.pop_front();
                end
                chk("word", data_out, cur);
                if (stall_req >= 0) begin
                    stall = stall_req;
                    stall_req = -1;
                    data_ready = 1'b0;
                end else if (!data_ready) begin
                    stall = $urandom_range(0, 3);
                end
            end else begin
                chk("hold_data", data_out, cur);
                chk("hold_cnt_en", cnt_en, 0);
            end
            if (!data_ready) begin
                if (stall == 0) data_ready = 1'b1;
                else stall--;
            end
            hs = data_ready;
            hs_en = enable;
        end else begin
            seen = 1'b0;
            data_ready = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic wait_count(output bit ok);
        int n;
        n = 0;
        while (!cnt_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = cnt_en;
        if (!ok) fail_now("window_start");
    endtask

    // One measurement window: assert ro_full at timer value d.
    task automatic do_window(input int d, input int hold);
        bit           ok;
        int           n;
        logic [W-1:0] w;
        bit           last;
        wait_count(ok);
        if (!ok) return;
        for (int j = 0; j < d; j++) @(negedge clk);
        chk("cnt_en_window", cnt_en, 1);
        ro_full = 1'b1;
        bits.push_back((d + 2) & 1);
        last = (bits.size() == W);
        if (last) begin
            w = '0;
            for (int i = 0; i < W; i++) w[W-1-i] = bits[i][0];
            sb.push_back(w);
            bits.delete();
        end
        n = 0;
        while (cnt_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sample_lat", n, 3);
        chk("sample_valid", data_valid, 0);
        if (last) begin
            @(negedge clk);
            chk("valid_rise", data_valid, 1);
        end
        repeat (hold) @(negedge clk);
        ro_full = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        int k;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_cnt_rst", cnt_rst, 1);
            chk("idle_cnt_en", cnt_en, 0);
            chk("idle_busy", busy, 0);
            chk("idle_valid", data_valid, 0);
        end

        // Reset mid-window.
        enable = 1'b1;
        wait_count(ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_cnt_rst", cnt_rst, 1);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_busy", busy, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Directed word 1010 with 10-cycle backpressure.
        stall_req = 10;
        do_window(3, 0);
        do_window(4, 0);
        do_window(3, 0);
        do_window(4, 0);

        // Stale full flag held into CLEAR.
        for (int i = 0; i < W; i++) do_window(5, 6);

        // Abort after two bits.
        do_window(2, 1);
        do_window(7, 2);
        wait_count(ok);
        enable = 1'b0;
        bits.delete();
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_cnt_rst", cnt_rst, 1);
        enable = 1'b1;
        for (int i = 0; i < W; i++) do_window(i + 1, 0);

        // Random windows.
        for (int i = 0; i < 6 * W; i++)
            do_window($urandom_range(0, 10), $urandom_range(0, 6));

        // Timeout: no full flag at all.
        wait_count(ok);
        n = 0;
        k = 0;
        while (!error && k < 100) begin
            if (cnt_en) n++;
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", n, 17);
        for (int i = 0; i < 5; i++) begin
            chk("err_flag", error, 1);
            chk("err_busy", busy, 0);
            chk("err_cnt_rst", cnt_rst, 1);
            @(negedge clk);
        end
        enable = 1'b0;
        bits.delete();
        @(negedge clk);
        chk("err_clear", error, 0);
        chk("err_idle_busy", busy, 0);

        // Recovery after error.
        enable = 1'b1;
        for (int i = 0; i < W; i++)
            do_window($urandom_range(0, 10), $urandom_range(0, 3));

        n = 0;
        while ((sb.size() != 0 || data_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) fail_now("drain");
        enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
